// File: rtl/uart_tx_arbiter.sv
// Two-channel round-robin arbiter that pops bytes from show-ahead FIFOs and
// hands them one at a time to a UART transmitter, with bursts and a WAIT timeout.
module uart_tx_arbiter #(
  parameter int WIDTH   = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Empty0,
  input  logic             Empty1,
  input  logic [WIDTH-1:0] ReadData0,
  input  logic [WIDTH-1:0] ReadData1,
  output logic             Read0,
  output logic             Read1,
  output logic [WIDTH-1:0] TxData,
  output logic             TxStart,
  input  logic             TxDone,
  output logic             Busy,
  output logic             GrantId,
  output logic             Error
);
  localparam int BW = $clog2(BURST + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] BurstMax    = BW'(BURST);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, START, WAIT} StateT;

  StateT            state, stateNext;
  logic             grantId, grantNext;
  logic             lastGrant, lastNext;
  logic [BW-1:0]    burstCnt, burstNext;
  logic [TW-1:0]    timeoutCnt, timeoutNext;
  logic [WIDTH-1:0] txData, dataNext;
  logic             error, errorNext;
  logic             headEmpty;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      grantId    <= 1'b0;
      lastGrant  <= 1'b1;
      burstCnt   <= '0;
      timeoutCnt <= '0;
      txData     <= '0;
      error      <= 1'b0;
    end else begin
      state      <= stateNext;
      grantId    <= grantNext;
      lastGrant  <= lastNext;
      burstCnt   <= burstNext;
      timeoutCnt <= timeoutNext;
      txData     <= dataNext;
      error      <= errorNext;
    end
  end

  always_comb begin
    stateNext   = state;
    grantNext   = grantId;
    lastNext    = lastGrant;
    burstNext   = burstCnt;
    timeoutNext = timeoutCnt;
    dataNext    = txData;
    errorNext   = error;
    Read0       = 1'b0;
    Read1       = 1'b0;
    TxStart     = 1'b0;
    headEmpty   = grantId ? Empty1 : Empty0;
    case (state)
      IDLE: begin
        if (!Empty0 || !Empty1) begin
          // Both requesting: alternate; otherwise Empty0 set means only channel 1 waits.
          grantNext = (!Empty0 && !Empty1) ? ~lastGrant : Empty0;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        Read0     = ~grantId;
        Read1     = grantId;
        dataNext  = grantId ? ReadData1 : ReadData0;
        if (burstCnt != BurstMax) burstNext = burstCnt + 1'b1;
        stateNext = START;
      end
      START: begin
        TxStart     = 1'b1;
        timeoutNext = '0;
        stateNext   = WAIT;
      end
      WAIT: begin
        // TxDone wins over a coinciding timeout, leaving Error untouched.
        if (TxDone) begin
          if (burstCnt < BurstMax && !headEmpty) begin
            stateNext = ISSUE;
          end else begin
            lastNext  = grantId;
            burstNext = '0;
            stateNext = IDLE;
          end
        end else if (timeoutCnt == TimeoutLast) begin
          errorNext = 1'b1;
          lastNext  = grantId;
          burstNext = '0;
          stateNext = IDLE;
        end else begin
          timeoutNext = timeoutCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign TxData  = txData;
  assign Busy    = (state != IDLE);
  assign GrantId = grantId;
  assign Error   = error;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: FIFO and transmitter models, vector table,
// directed corner sequences and randomized runs against a burst-level model.
module tb_uart_tx_arbiter;
  localparam int WIDTH = 8, BURST = 4, TIMEOUT = 20;

  logic Clock = 1'b0;
  logic Reset, Empty0, Empty1, Read0, Read1, TxStart, TxDone, Busy, GrantId, Error;
  logic [WIDTH-1:0] ReadData0, ReadData1, TxData;

  uart_tx_arbiter #(.WIDTH(WIDTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .Empty0(Empty0), .Empty1(Empty1),
    .ReadData0(ReadData0), .ReadData1(ReadData1), .Read0(Read0), .Read1(Read1),
    .TxData(TxData), .TxStart(TxStart), .TxDone(TxDone), .Busy(Busy),
    .GrantId(GrantId), .Error(Error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int n0; int n1; int nexp; int nidle;
    logic [95:0] exp;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] q0[$], q1[$];
  logic [8:0] sentQ[$], expQ[$];
  int checks = 0, failures = 0;
  int doneIn = -1, forceDone = 0, delayFix = 3;
  bit autoDone = 1'b1, spurious = 1'b0, randDelay = 1'b0;
  int nRd0, nRd1, bothRd, idleSeen;
  logic sRead0, sRead1, sTxStart, sBusy, sGrant, sError, sTxDone;
  logic [7:0] sTxData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    Empty0 = (q0.size() == 0);
    Empty1 = (q1.size() == 0);
    ReadData0 = Empty0 ? 8'h00 : q0[0];
    ReadData1 = Empty1 ? 8'h00 : q1[0];
  endtask

  // One clock: drive TxDone, sample outputs mid-cycle, then pop FIFOs after the edge.
  task automatic cycle();
    TxDone = 1'b0;
    if (doneIn > 0) begin
      doneIn--;
      if (doneIn == 0) begin TxDone = 1'b1; doneIn = -1; end
    end else if (spurious && doneIn < 0 && $urandom_range(3) == 0) TxDone = 1'b1;
    if (forceDone > 0) begin TxDone = 1'b1; forceDone--; end
    sRead0 = Read0; sRead1 = Read1; sTxStart = TxStart; sBusy = Busy;
    sGrant = GrantId; sError = Error; sTxDone = TxDone; sTxData = TxData;
    if (Read0) nRd0++;
    if (Read1) nRd1++;
    if (Read0 && Read1) bothRd++;
    if (!Busy && sentQ.size() > 0) idleSeen++;
    if (TxStart) begin
      sentQ.push_back({GrantId, TxData});
      if (autoDone) doneIn = randDelay ? int'($urandom_range(1, 12)) : delayFix;
    end
    @(posedge Clock); #1;
    if (sRead0 && q0.size() > 0) void'(q0.pop_front());
    if (sRead1 && q1.size() > 0) void'(q1.pop_front());
    refresh();
  endtask

  task automatic clearLog();
    sentQ.delete(); nRd0 = 0; nRd1 = 0; bothRd = 0; idleSeen = 0;
  endtask

  task automatic resetDut();
    Reset = 1'b1; q0.delete(); q1.delete(); refresh();
    TxDone = 1'b0; doneIn = -1; forceDone = 0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    clearLog();
  endtask

  task automatic runUntilIdle(input string name, input int want);
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      if (sentQ.size() >= want && doneIn < 0 && !Busy) begin ok = 1'b1; break; end
    end
    chk($sformatf("%s drained", name), 32'(ok), 32'd1);
  endtask

  task automatic compare(input string tag, input logic [8:0] exp[$], input int e0, input int e1);
    chk($sformatf("%s count", tag), sentQ.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      if (k < sentQ.size()) chk($sformatf("%s byte%0d", tag, k), 32'(sentQ[k]), 32'(exp[k]));
    chk($sformatf("%s reads0", tag), nRd0, e0);
    chk($sformatf("%s reads1", tag), nRd1, e1);
    chk($sformatf("%s dual read", tag), bothRd, 0);
  endtask

  // Expected {channel, byte} order from round-robin at burst granularity.
  function automatic void model(input logic [7:0] a[$], input logic [7:0] b[$],
                                output logic [8:0] e[$]);
    bit last = 1'b1;
    bit ch;
    e.delete();
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) ch = ~last;
      else ch = (a.size() == 0);
      for (int k = 0; k < BURST; k++) begin
        if (!ch && a.size() > 0) e.push_back({1'b0, a.pop_front()});
        else if (ch && b.size() > 0) e.push_back({1'b1, b.pop_front()});
      end
      last = ch;
    end
  endfunction

  initial begin
    int n0, n1;
    logic [7:0] e8;
    vecs[0] = '{1, 0, 1, 0, {8'h00, 88'h0}};
    vecs[1] = '{0, 1, 1, 0, {8'h10, 88'h0}};
    vecs[2] = '{6, 6, 12, 3, {8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                              8'h04, 8'h05, 8'h14, 8'h15}};
    vecs[3] = '{9, 0, 9, 2, {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                             8'h08, 24'h0}};
    vecs[4] = '{2, 5, 7, 2, {8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 40'h0}};
    vecs[5] = '{5, 1, 6, 2, {8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h04, 48'h0}};

    Reset = 1'b1; TxDone = 1'b0; refresh();
    resetDut();
    chk("rst Busy", Busy, 0);       chk("rst GrantId", GrantId, 0);
    chk("rst Error", Error, 0);     chk("rst TxStart", TxStart, 0);
    chk("rst Read0", Read0, 0);     chk("rst Read1", Read1, 0);
    chk("rst TxData", TxData, 0);

    for (int i = 0; i < 6; i++) begin
      resetDut();
      for (int k = 0; k < vecs[i].n0; k++) q0.push_back(8'(k));
      for (int k = 0; k < vecs[i].n1; k++) q1.push_back(8'(8'h10 + k));
      refresh();
      expQ.delete();
      for (int k = 0; k < vecs[i].nexp; k++) begin
        e8 = vecs[i].exp[8*(11-k) +: 8];
        expQ.push_back({e8[4], e8});
      end
      runUntilIdle($sformatf("vec%0d", i), vecs[i].nexp);
      compare($sformatf("vec%0d", i), expQ, vecs[i].n0, vecs[i].n1);
      chk($sformatf("vec%0d idle gaps", i), idleSeen, vecs[i].nidle);
    end

    // Single byte with cycle-exact latency
    resetDut(); delayFix = 10;
    q0.push_back(8'hA5); refresh();
    cycle(); chk("sb idle Read0", sRead0, 0); chk("sb idle Busy", sBusy, 0);
    cycle(); chk("sb issue Read0", sRead0, 1); chk("sb issue Read1", sRead1, 0);
    chk("sb issue TxStart", sTxStart, 0);
    cycle(); chk("sb start TxStart", sTxStart, 1); chk("sb start TxData", sTxData, 8'hA5);
    chk("sb start Read0", sRead0, 0);
    repeat (10) cycle();
    chk("sb done Busy", sBusy, 1);
    cycle(); chk("sb after Busy", sBusy, 0); chk("sb after GrantId", sGrant, 0);
    delayFix = 3;

    // Timeout: no TxDone for the first byte
    resetDut(); autoDone = 1'b0;
    q0.push_back(8'h77); q0.push_back(8'h78); refresh();
    cycle(); cycle(); cycle();
    chk("to start", sTxStart, 1); chk("to data", sTxData, 8'h77);
    repeat (20) cycle();
    chk("to err early", sError, 0); chk("to busy wait", sBusy, 1);
    cycle(); chk("to err set", sError, 1); chk("to idle", sBusy, 0);
    cycle(); chk("to reissue Read0", sRead0, 1);
    cycle(); chk("to next start", sTxStart, 1); chk("to next data", sTxData, 8'h78);
    autoDone = 1'b1; doneIn = 4;
    runUntilIdle("to", 2);
    chk("to err sticky", Error, 1);

    // Reset while waiting on 0x3C
    resetDut();
    q1.push_back(8'h3C); refresh();
    cycle(); cycle(); cycle();
    chk("rw start data", sTxData, 8'h3C);
    cycle();
    q0.push_back(8'h11); q1.push_back(8'h22); refresh();
    Reset = 1'b1; TxDone = 1'b0; doneIn = -1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("rw Busy", Busy, 0);       chk("rw TxStart", TxStart, 0);
    chk("rw Read0", Read0, 0);     chk("rw Read1", Read1, 0);
    chk("rw GrantId", GrantId, 0); chk("rw Error", Error, 0);
    chk("rw TxData", TxData, 0);
    clearLog();
    runUntilIdle("rw", 2);
    expQ = '{9'h011, 9'h122};
    compare("rw", expQ, 1, 1);

    // Spurious TxDone in IDLE, ISSUE and START
    resetDut(); forceDone = 1;
    cycle(); chk("sp idle1", sBusy, 0);
    cycle(); chk("sp idle2", sBusy, 0);
    q0.push_back(8'h42); refresh(); forceDone = 3; delayFix = 5;
    runUntilIdle("sp", 1);
    expQ = '{9'h042};
    compare("sp", expQ, 1, 0);
    delayFix = 3;

    // Randomized traffic with random TxDone latency and spurious pulses
    spurious = 1'b1; randDelay = 1'b1;
    for (int r = 0; r < 8; r++) begin
      resetDut();
      n0 = $urandom_range(0, 10);
      n1 = $urandom_range(0, 10);
      for (int k = 0; k < n0; k++) q0.push_back(8'($urandom));
      for (int k = 0; k < n1; k++) q1.push_back(8'($urandom));
      refresh();
      model(q0, q1, expQ);
      runUntilIdle($sformatf("rnd%0d", r), expQ.size());
      compare($sformatf("rnd%0d", r), expQ, n0, n1);
      chk($sformatf("rnd%0d error", r), Error, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
